// File: rtl/memtest_pkg.sv
// Shared definitions for the memtest read-back path: PRBS16 step, default
// seed and the checker state encoding.
package memtest_pkg;

    localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } chk_state_t;

    // One step of the PRBS16 sequence used by both generator and checker.
    function automatic logic [15:0] prbs16(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
    endfunction

endpackage

// File: rtl/memtest_check_if.sv
// Bundle of control, read-data and status signals around memtest_check.
//
// Handshake: rd_valid qualifies data_in for exactly the cycle it is high;
// there is no ready, the checker accepts one beat per cycle unconditionally.
// start is a single-cycle pulse with the same sampling rule.
interface memtest_check_if
    import memtest_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int IDX_W = 7
);
    logic              start;
    logic              rd_valid;
    logic [31:0]       data_in;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  err_count;
    logic [31:0]       err_mask;
    logic [IDX_W-1:0]  first_err_idx;
    logic              first_err_vld;
    logic [15:0]       exp_data;
    chk_state_t        state_dbg;

    modport master (
        output start, rd_valid, data_in,
        input  busy, done, pass, err_count, err_mask,
               first_err_idx, first_err_vld, exp_data, state_dbg
    );

    modport slave (
        input  start, rd_valid, data_in,
        output busy, done, pass, err_count, err_mask,
               first_err_idx, first_err_vld, exp_data, state_dbg
    );
endinterface

// File: rtl/memtest_prbs.sv
// 16-bit PRBS LFSR with synchronous load-to-seed and advance controls.
// load has priority over advance.
module memtest_prbs
    import memtest_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] q
);
    logic [15:0] q_q;
    logic [15:0] q_d;

    // Next LFSR value: reload, step, or hold.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = SEED;
        end else if (advance) begin
            q_d = prbs16(q_q);
        end
    end

    // LFSR register, seeded on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/memtest_check.sv
// Read-back checker: compares each read beat against {exp,exp} from a local
// PRBS16 and accumulates sticky error status over DEPTH*PASSES beats.
module memtest_check
    import memtest_pkg::*;
#(
    parameter logic [15:0] SEED   = DEFAULT_SEED,
    parameter int          DEPTH  = 32,
    parameter int          PASSES = 4,
    parameter int          CNT_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    memtest_check_if.slave  bus
);
    localparam int TOTAL  = DEPTH * PASSES;
    localparam int IDX_W  = (TOTAL  > 1) ? $clog2(TOTAL)  : 1;
    localparam int BEAT_W = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DEPTH - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);

    chk_state_t        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [31:0]       err_mask_q, err_mask_d;
    logic [IDX_W-1:0]  first_idx_q, first_idx_d;
    logic              first_vld_q, first_vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic              prbs_load;
    logic              prbs_advance;
    logic [15:0]       exp_val;
    logic [31:0]       diff;
    logic              mismatch;
    logic [31:0]       beat_idx;

    memtest_prbs #(.SEED(SEED)) u_prbs (
        .clk     (clk),
        .rst     (rst),
        .load    (prbs_load),
        .advance (prbs_advance),
        .q       (exp_val)
    );

    assign diff     = bus.data_in ^ {exp_val, exp_val};
    assign mismatch = |diff;
    assign beat_idx = 32'(pass_cnt_q) * 32'(DEPTH) + 32'(beat_q);

    // FSM next state plus counter, compare and capture updates.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        pass_cnt_d   = pass_cnt_q;
        err_count_d  = err_count_q;
        err_mask_d   = err_mask_q;
        first_idx_d  = first_idx_q;
        first_vld_d  = first_vld_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        prbs_load    = 1'b0;
        prbs_advance = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                // rd_valid is ignored here; start arms a fresh run.
                if (bus.start) begin
                    state_d     = CHECK;
                    prbs_load   = 1'b1;
                    beat_d      = '0;
                    pass_cnt_d  = '0;
                    err_count_d = '0;
                    err_mask_d  = '0;
                    first_idx_d = '0;
                    first_vld_d = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                end
            end
            CHECK: begin
                // start is ignored while a run is in progress.
                if (bus.rd_valid) begin
                    prbs_advance = 1'b1;
                    err_mask_d   = err_mask_q | diff;
                    if (mismatch) begin
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (!first_vld_q) begin
                            first_idx_d = IDX_W'(beat_idx);
                            first_vld_d = 1'b1;
                        end
                    end
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        if (pass_cnt_q == LAST_PASS) begin
                            pass_cnt_d = '0;
                            state_d    = DONE;
                            busy_d     = 1'b0;
                            done_d     = 1'b1;
                            pass_d     = (err_count_d == '0);
                        end else begin
                            pass_cnt_d = pass_cnt_q + 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    // State and status registers; reset discards any partial run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            pass_cnt_q  <= '0;
            err_count_q <= '0;
            err_mask_q  <= '0;
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            pass_cnt_q  <= pass_cnt_d;
            err_count_q <= err_count_d;
            err_mask_q  <= err_mask_d;
            first_idx_q <= first_idx_d;
            first_vld_q <= first_vld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.err_count     = err_count_q;
    assign bus.err_mask      = err_mask_q;
    assign bus.first_err_idx = first_idx_q;
    assign bus.first_err_vld = first_vld_q;
    assign bus.exp_data      = exp_val;
    assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_memtest_check.sv
// Bench for memtest_check: two instances share one stimulus stream, the
// second with a 4-bit error counter to exercise saturation.
module tb_memtest_check;
    localparam int DEPTH  = 32;
    localparam int PASSES = 4;
    localparam int TOTAL  = DEPTH * PASSES;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start    = 1'b0;
    logic        rd_valid = 1'b0;
    logic [31:0] data_in  = '0;

    memtest_check_if #(.CNT_W(16), .IDX_W(7)) bus0 ();
    memtest_check_if #(.CNT_W(4),  .IDX_W(7)) bus1 ();

    assign bus0.start    = start;
    assign bus0.rd_valid = rd_valid;
    assign bus0.data_in  = data_in;
    assign bus1.start    = start;
    assign bus1.rd_valid = rd_valid;
    assign bus1.data_in  = data_in;

    memtest_check #(.SEED(16'hFFFF), .DEPTH(DEPTH), .PASSES(PASSES), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    memtest_check #(.SEED(16'hFFFF), .DEPTH(DEPTH), .PASSES(PASSES), .CNT_W(4)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // ---------------- reference model / scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] seq [TOTAL+1];
    logic [31:0] stim [TOTAL];
    logic [15:0] exp_q [$];
    int          run_err;
    int          m_errs;
    logic [31:0] m_mask;
    int          m_first;
    bit          m_vld;

    // Expected PRBS sequence from the seed using plain integer arithmetic.
    function automatic void build_seq();
        int s;
        int fb;
        s = 16'hFFFF;
        for (int i = 0; i <= TOTAL; i++) begin
            seq[i] = s[15:0];
            fb = ((s >> 15) ^ (s >> 14) ^ (s >> 12) ^ (s >> 3)) & 1;
            s  = ((s << 1) | fb) & 16'hFFFF;
        end
    endfunction

    function automatic void clean_stim();
        for (int i = 0; i < TOTAL; i++) stim[i] = {seq[i], seq[i]};
    endfunction

    // Whole-run expected results from the stimulus table.
    function automatic void model();
        logic [31:0] d;
        m_errs = 0; m_mask = '0; m_first = 0; m_vld = 1'b0;
        for (int i = 0; i < TOTAL; i++) begin
            d = stim[i] ^ {seq[i], seq[i]};
            m_mask |= d;
            if (d != 0) begin
                m_errs++;
                if (!m_vld) begin
                    m_vld   = 1'b1;
                    m_first = i;
                end
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit with_valid, input logic [31:0] d);
        start    = 1'b1;
        rd_valid = with_valid;
        data_in  = d;
        tick();
        start    = 1'b0;
        rd_valid = 1'b0;
        run_err  = 0;
        exp_q.delete();
        n_checks++;
        if (bus0.busy !== 1'b1 || bus0.done !== 1'b0 || bus0.exp_data !== 16'hFFFF
            || bus0.err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL start_arm: busy=%b done=%b exp=%h err=%0d, required busy=1 done=0 exp=ffff err=0",
                     bus0.busy, bus0.done, bus0.exp_data, bus0.err_count);
        end
    endtask

    // Feed beats [from,to) with random idle gaps; optional start pulse in an
    // idle cycle before beat mid_start.
    task automatic feed(input int from, input int to, input int gap_max,
                        input int pass_gap, input int mid_start);
        int          n;
        logic [15:0] cnt_before;
        logic [31:0] mask_before;
        logic [15:0] exp_before;
        for (int i = from; i < to; i++) begin
            n = $urandom_range(gap_max, 0);
            if (i > 0 && (i % DEPTH) == 0) n += pass_gap;
            for (int k = 0; k < n; k++) begin
                rd_valid = 1'b0;
                data_in  = $urandom;
                tick();
            end
            if (i == mid_start) begin
                cnt_before  = bus0.err_count;
                mask_before = bus0.err_mask;
                exp_before  = bus0.exp_data;
                start    = 1'b1;
                rd_valid = 1'b0;
                tick();
                start = 1'b0;
                n_checks++;
                if (bus0.err_count !== cnt_before || bus0.err_mask !== mask_before
                    || bus0.exp_data !== exp_before || bus0.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mid_start: err=%0d mask=%h exp=%h busy=%b, required err=%0d mask=%h exp=%h busy=1",
                             bus0.err_count, bus0.err_mask, bus0.exp_data, bus0.busy,
                             cnt_before, mask_before, exp_before);
                end
            end
            rd_valid = 1'b1;
            data_in  = stim[i];
            if (stim[i] !== {seq[i], seq[i]}) run_err++;
            exp_q.push_back(seq[i+1]);
            tick();
            rd_valid = 1'b0;
            begin
                logic [15:0] e;
                e = exp_q.pop_front();
                n_checks++;
                if (bus0.exp_data !== e || bus0.err_count !== 16'(run_err)) begin
                    n_fail++;
                    $display("FAIL beat_%0d: exp_data=%h err=%0d, required exp_data=%h err=%0d",
                             i, bus0.exp_data, bus0.err_count, e, run_err);
                end
            end
            n_checks++;
            if (i < TOTAL - 1 && (bus0.busy !== 1'b1 || bus0.done !== 1'b0)) begin
                n_fail++;
                $display("FAIL busy_%0d: busy=%b done=%b, required busy=1 done=0",
                         i, bus0.busy, bus0.done);
            end else if (i == TOTAL - 1 && (bus0.busy !== 1'b0 || bus0.done !== 1'b1)) begin
                n_fail++;
                $display("FAIL complete: busy=%b done=%b, required busy=0 done=1",
                         bus0.busy, bus0.done);
            end
        end
    endtask

    task automatic check_final(input string name);
        int sat;
        model();
        sat = (m_errs > 15) ? 15 : m_errs;
        n_checks++;
        if (bus0.done !== 1'b1 || bus0.busy !== 1'b0 || bus0.pass !== (m_errs == 0)
            || bus0.err_count !== 16'(m_errs) || bus0.err_mask !== m_mask
            || bus0.first_err_vld !== m_vld) begin
            n_fail++;
            $display("FAIL %s: done=%b busy=%b pass=%b err=%0d mask=%h fvld=%b, required done=1 busy=0 pass=%b err=%0d mask=%h fvld=%b",
                     name, bus0.done, bus0.busy, bus0.pass, bus0.err_count, bus0.err_mask,
                     bus0.first_err_vld, (m_errs == 0), m_errs, m_mask, m_vld);
        end
        n_checks++;
        if (m_vld && bus0.first_err_idx !== 7'(m_first)) begin
            n_fail++;
            $display("FAIL %s_idx: first_err_idx=%0d, required %0d", name, bus0.first_err_idx, m_first);
        end
        n_checks++;
        if (bus1.err_count !== 4'(sat) || bus1.done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_sat: err_count=%0d done=%b, required %0d done=1",
                     name, bus1.err_count, bus1.done, sat);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus0.busy !== 1'b0 || bus0.done !== 1'b0 || bus0.pass !== 1'b0
            || bus0.err_count !== 16'd0 || bus0.err_mask !== 32'd0 || bus0.first_err_idx !== 7'd0
            || bus0.first_err_vld !== 1'b0 || bus0.exp_data !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b pass=%b err=%0d mask=%h idx=%0d fvld=%b exp=%h, required all 0 and exp=ffff",
                     bus0.busy, bus0.done, bus0.pass, bus0.err_count, bus0.err_mask,
                     bus0.first_err_idx, bus0.first_err_vld, bus0.exp_data);
        end
        // rd_valid in IDLE must not be checked.
        rd_valid = 1'b1;
        data_in  = 32'h1234_5678;
        tick();
        rd_valid = 1'b0;
        n_checks++;
        if (bus0.err_count !== 16'd0 || bus0.exp_data !== 16'hFFFF || bus0.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignore: err=%0d exp=%h busy=%b, required 0 ffff 0",
                     bus0.err_count, bus0.exp_data, bus0.busy);
        end
    endtask

    task automatic test_clean();
        n_checks++;
        if (seq[0] !== 16'hFFFF || seq[1] !== 16'hFFFE || seq[2] !== 16'hFFFC) begin
            n_fail++;
            $display("FAIL model_seq: %h %h %h, required ffff fffe fffc", seq[0], seq[1], seq[2]);
        end
        clean_stim();
        do_start(1'b0, 32'h0);
        feed(0, TOTAL, 0, 32, -1);
        check_final("clean");
    endtask

    task automatic test_single();
        clean_stim();
        stim[37] ^= 32'h1;
        do_start(1'b0, 32'h0);
        feed(0, TOTAL, 2, 0, -1);
        check_final("single");
        n_checks++;
        if (bus0.err_mask !== 32'h0000_0001 || bus0.first_err_idx !== 7'd37 || bus0.pass !== 1'b0) begin
            n_fail++;
            $display("FAIL single_fixed: mask=%h idx=%0d pass=%b, required 00000001 37 0",
                     bus0.err_mask, bus0.first_err_idx, bus0.pass);
        end
    endtask

    task automatic test_half();
        clean_stim();
        stim[0] = 32'hFFFF_0000;
        do_start(1'b0, 32'h0);
        feed(0, TOTAL, 1, 0, -1);
        check_final("half");
        n_checks++;
        if (bus0.err_count !== 16'd1 || bus0.err_mask !== 32'h0000_FFFF) begin
            n_fail++;
            $display("FAIL half_fixed: err=%0d mask=%h, required 1 0000ffff",
                     bus0.err_count, bus0.err_mask);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < TOTAL; i++) stim[i] = 32'h0;
        do_start(1'b0, 32'h0);
        feed(0, TOTAL, 0, 0, -1);
        check_final("saturate");
        n_checks++;
        if (bus1.err_count !== 4'hF || bus1.first_err_idx !== 7'd0 || bus1.pass !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_fixed: err=%h idx=%0d pass=%b, required f 0 0",
                     bus1.err_count, bus1.first_err_idx, bus1.pass);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            clean_stim();
            for (int k = 0; k < int'($urandom_range(6, 1)); k++) begin
                int p;
                p = $urandom_range(TOTAL - 1, 0);
                stim[p] ^= (32'h1 << $urandom_range(31, 0));
            end
            do_start(1'b0, 32'h0);
            feed(0, TOTAL, 3, 0, -1);
            check_final("random");
        end
    endtask

    task automatic test_events();
        // Garbage beat with start must be skipped; an early error then a
        // start pulse mid-run must not disturb the accumulated status.
        clean_stim();
        stim[5] ^= 32'h8000_0000;
        do_start(1'b1, 32'h0000_0000);
        feed(0, TOTAL, 1, 0, 20);
        check_final("events");
        // Beats after DONE are ignored and done is held.
        for (int k = 0; k < 4; k++) begin
            rd_valid = 1'b1;
            data_in  = $urandom;
            tick();
        end
        rd_valid = 1'b0;
        n_checks++;
        if (bus0.err_count !== 16'd1 || bus0.done !== 1'b1 || bus0.err_mask !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL done_hold: err=%0d done=%b mask=%h, required 1 1 80000000",
                     bus0.err_count, bus0.done, bus0.err_mask);
        end
    endtask

    task automatic test_reset_mid();
        clean_stim();
        stim[3] = 32'hDEAD_BEEF;
        do_start(1'b0, 32'h0);
        feed(0, 50, 1, 0, -1);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus0.busy !== 1'b0 || bus0.done !== 1'b0 || bus0.pass !== 1'b0
            || bus0.err_count !== 16'd0 || bus0.err_mask !== 32'd0 || bus0.first_err_idx !== 7'd0
            || bus0.first_err_vld !== 1'b0 || bus0.exp_data !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b pass=%b err=%0d mask=%h idx=%0d fvld=%b exp=%h, required all 0 and exp=ffff",
                     bus0.busy, bus0.done, bus0.pass, bus0.err_count, bus0.err_mask,
                     bus0.first_err_idx, bus0.first_err_vld, bus0.exp_data);
        end
        tick();
        rst = 1'b0;
        tick();
        clean_stim();
        do_start(1'b0, 32'h0);
        feed(0, TOTAL, 1, 0, -1);
        check_final("after_reset");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        build_seq();
        test_reset();
        test_clean();
        test_single();
        test_half();
        test_saturation();
        test_random();
        test_events();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
